// File: rtl/sar_search_4bit_pkg.sv
// Shared constants for the successive-approximation search controller:
// FSM state encodings and the {gt,eq,lt} comparator answer codes.
package sar_search_4bit_pkg;

  localparam int unsigned SAR_WIDTH = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

endpackage

// File: rtl/sar_search_4bit.sv
// Successive-approximation controller: presents a trial value to an external
// magnitude comparator and recovers the unknown operand by binary search.
module sar_search_4bit
  import sar_search_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             early,
  output logic             err
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] TRIAL_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  // Decide bit idx from the comparator and tentatively set the next lower bit.
  function automatic logic [WIDTH-1:0] next_trial(input logic [WIDTH-1:0] t_in,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic             gt);
    logic [WIDTH-1:0] t;
    t    = t_in;
    t[i] = gt;
    if (i != '0) t[i - IDX_W'(1)] = 1'b1;
    return t;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             early_q, early_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       cmp_code;
  logic [WIDTH-1:0] upd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      trial_q  <= '0;
      idx_q    <= IDX_MSB;
      result_q <= '0;
      early_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      early_q  <= early_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    idx_d    = idx_q;
    result_d = result_q;
    early_d  = early_q;
    err_d    = err_q;
    cmp_code = {cmp_gt, cmp_eq, cmp_lt};
    upd      = next_trial(trial_q, idx_q, cmp_gt);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COMPARE;
          trial_d = TRIAL_MSB;
          idx_d   = IDX_MSB;
          early_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_COMPARE: begin
        case (cmp_code)
          CMP_EQ: begin
            result_d = trial_q;
            early_d  = (idx_q != '0);
            state_d  = ST_DONE;
          end
          CMP_GT, CMP_LT: begin
            if (idx_q == '0) begin
              result_d = upd;
              early_d  = 1'b0;
              state_d  = ST_DONE;
            end else begin
              trial_d = upd;
              idx_d   = idx_q - IDX_W'(1);
            end
          end
          // Anything not one-hot is a broken comparator.
          default: begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = ST_DONE;
          end
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_COMPARE);
    done_d = (state_d == ST_DONE);
  end

  assign trial  = trial_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign early  = early_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Directed bench: closes the loop through a behavioural 4-bit magnitude
// comparator with a fixed A, plus forced illegal codes and mid-search reset.
module tb_sar_search_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cmp_gt, cmp_eq, cmp_lt;
  logic [3:0] trial;
  logic       busy, done, early, err;
  logic [3:0] result;

  logic [3:0] a_val;
  logic       force_en;
  logic [2:0] force_code;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sar_search_4bit #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .cmp_lt (cmp_lt),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .early  (early),
    .err    (err)
  );

  always_comb begin
    if (force_en) begin
      {cmp_gt, cmp_eq, cmp_lt} = force_code;
    end else begin
      cmp_gt = (a_val > trial);
      cmp_eq = (a_val == trial);
      cmp_lt = (a_val < trial);
    end
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full search; exp_tr holds the expected trial per COMPARE cycle, MSB nibble first.
  task automatic run_search(input logic [3:0] a, input int k, input logic [15:0] exp_tr,
                            input logic [3:0] exp_res, input logic exp_early, input bit poke);
    logic [3:0] et;
    a_val = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_on", 8'(busy), 8'(1));
    for (int i = 0; i < k; i++) begin
      et = exp_tr[15 - 4*i -: 4];
      chk("trial", 8'(trial), 8'(et));
      chk("no_done_yet", 8'(done), 8'(0));
      if (poke && i == 1) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("done", 8'(done), 8'(1));
    chk("busy_off", 8'(busy), 8'(0));
    chk("result", 8'(result), 8'(exp_res));
    chk("early", 8'(early), 8'(exp_early));
    chk("err", 8'(err), 8'(0));
    tick();
    chk("done_pulse", 8'(done), 8'(0));
    chk("result_hold", 8'(result), 8'(exp_res));
  endtask

  initial begin
    int seen_done;
    rst        = 1'b1;
    start      = 1'b0;
    a_val      = 4'd0;
    force_en   = 1'b0;
    force_code = 3'b000;
    tick();
    tick();
    chk("rst_trial", 8'(trial), 8'(0));
    chk("rst_busy", 8'(busy), 8'(0));
    chk("rst_done", 8'(done), 8'(0));
    chk("rst_result", 8'(result), 8'(0));
    chk("rst_flags", 8'({early, err}), 8'(0));
    rst = 1'b0;
    tick();

    // A, k, trials, result, early, poke
    run_search(4'd5,  4, 16'h8465, 4'd5,  1'b0, 1'b0);
    run_search(4'd0,  4, 16'h8421, 4'd0,  1'b0, 1'b0);
    run_search(4'd15, 4, 16'h8CEF, 4'd15, 1'b0, 1'b0);
    run_search(4'd8,  1, 16'h8000, 4'd8,  1'b1, 1'b0);
    run_search(4'd6,  3, 16'h8460, 4'd6,  1'b1, 1'b0);
    run_search(4'd11, 4, 16'h8CAB, 4'd11, 1'b0, 1'b0);
    // start pulsed mid-search must not disturb the sequence
    run_search(4'd9,  4, 16'h8CA9, 4'd9,  1'b0, 1'b1);

    // Illegal comparator code on the 2nd COMPARE cycle
    a_val = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    force_en   = 1'b1;
    force_code = 3'b101;
    tick();
    force_en = 1'b0;
    chk("err_done", 8'(done), 8'(1));
    chk("err_flag", 8'(err), 8'(1));
    chk("err_result", 8'(result), 8'(0));
    tick();
    chk("err_hold", 8'(err), 8'(1));
    chk("err_pulse", 8'(done), 8'(0));
    a_val = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_cleared", 8'(err), 8'(0));
    repeat (5) tick();

    // Reset asserted during the 3rd COMPARE cycle
    a_val = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 8'(busy), 8'(0));
    chk("rst_mid_trial", 8'(trial), 8'(0));
    chk("rst_mid_done", 8'(done), 8'(0));
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen_done++;
      tick();
    end
    chk("rst_mid_no_done", 8'(seen_done), 8'(0));
    chk("rst_mid_idle", 8'(busy), 8'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
